// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of JK cells with a shadow of the expected bank state.
// Optional readback check of i_Q_BUS in DONE is enabled by defining JK_SEQ_READBACK_CHECK_EN.
module jk_bank_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             i_CLOCK_POS,
    input  logic             i_RESET_POS,
    input  logic             i_CMD_VALID,
    output logic             o_CMD_READY,
    input  logic [2:0]       i_CMD_OP,
    input  logic [WIDTH-1:0] i_CMD_MASK,
    input  logic [CNT_W-1:0] i_CMD_REPEAT,
    output logic [WIDTH-1:0] o_J_BUS,
    output logic [WIDTH-1:0] o_K_BUS,
    output logic             o_PRESET_NEG,
    output logic             o_RESET_NEG,
    input  logic [WIDTH-1:0] i_Q_BUS,
    output logic [WIDTH-1:0] o_EXPECTED,
    output logic             o_DONE,
    output logic             o_ILLEGAL,
    output logic             o_MISMATCH
);

    typedef enum logic [1:0] {StIdle, StApply, StDone} state_e;

    localparam logic [2:0] OpHold      = 3'd0;
    localparam logic [2:0] OpClear     = 3'd1;
    localparam logic [2:0] OpSet       = 3'd2;
    localparam logic [2:0] OpToggle    = 3'd3;
    localparam logic [2:0] OpResetAll  = 3'd4;
    localparam logic [2:0] OpPresetAll = 3'd5;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] j_drv, k_drv;
    logic             preset_drv, reset_drv;
    logic             done_drv, mismatch_drv;

    always_ff @(posedge i_CLOCK_POS) begin
        if (i_RESET_POS) begin
            state_q   <= StIdle;
            op_q      <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            exp_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        illegal_d   = illegal_q;
        o_CMD_READY = 1'b0;
        j_drv       = '0;
        k_drv       = '0;
        preset_drv  = 1'b0;
        reset_drv   = 1'b0;
        done_drv    = 1'b0;

        case (state_q)
            StIdle: begin
                o_CMD_READY = 1'b1;
                if (i_CMD_VALID) begin
                    op_d      = i_CMD_OP;
                    mask_d    = i_CMD_MASK;
                    illegal_d = i_CMD_OP[2] & i_CMD_OP[1];
                    // Bank-wide ops run for a single cycle regardless of the repeat field
                    cnt_d     = i_CMD_OP[2] ? '0 : i_CMD_REPEAT;
                    state_d   = (i_CMD_OP[2] & i_CMD_OP[1]) ? StDone : StApply;
                end
            end
            StApply: begin
                case (op_q)
                    OpHold: ;
                    OpClear: begin
                        k_drv = mask_q;
                        exp_d = exp_q & ~mask_q;
                    end
                    OpSet: begin
                        j_drv = mask_q;
                        exp_d = exp_q | mask_q;
                    end
                    OpToggle: begin
                        j_drv = mask_q;
                        k_drv = mask_q;
                        exp_d = exp_q ^ mask_q;
                    end
                    OpResetAll: begin
                        reset_drv = 1'b1;
                        exp_d     = '0;
                    end
                    OpPresetAll: begin
                        preset_drv = 1'b1;
                        exp_d      = '1;
                    end
                    default: ;
                endcase
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                done_drv = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef JK_SEQ_READBACK_CHECK_EN
    assign mismatch_drv = (state_q == StDone) && !illegal_q && (i_Q_BUS != exp_q);
`else
    logic unused_q_bus;
    assign unused_q_bus = ^i_Q_BUS;
    assign mismatch_drv = 1'b0;
`endif

    // Reset overrides every bank drive so the bank clears on the same edge as the controller
    assign o_J_BUS      = i_RESET_POS ? '0 : j_drv;
    assign o_K_BUS      = i_RESET_POS ? '0 : k_drv;
    assign o_RESET_NEG  = ~(i_RESET_POS | reset_drv);
    assign o_PRESET_NEG = ~(preset_drv & ~i_RESET_POS);
    assign o_EXPECTED   = exp_q;
    assign o_DONE       = done_drv & ~i_RESET_POS;
    assign o_ILLEGAL    = done_drv & illegal_q & ~i_RESET_POS;
    assign o_MISMATCH   = mismatch_drv & ~i_RESET_POS;

endmodule
